// File: rtl/exu_pkg.sv
// ---------------------------------------------------------------------------
// exu_pkg
// Shared definitions for the execution-unit sequencer: FSM state encoding,
// trap cause codes, execution-unit index constants and parameter defaults.
// No ports.
// ---------------------------------------------------------------------------
package exu_pkg;

    localparam int NUM_UNITS_DEF   = 8;
    localparam int EXEC_CYCLES_DEF = 4;
    localparam int STALL_MAX_DEF   = 255;

    // Bit positions of each execution unit in the one-hot select/enable vectors.
    localparam int EXU_IMM = 0;   // immediate ALU
    localparam int EXU_REG = 1;   // register ALU
    localparam int EXU_BR  = 2;   // branch
    localparam int EXU_LSU = 3;   // load/store
    localparam int EXU_MUL = 4;   // multiplier
    localparam int EXU_DIV = 5;   // divider
    localparam int EXU_CSR = 6;   // control/status registers
    localparam int EXU_SYS = 7;   // system / misc

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_RETIRE = 3'd4,
        ST_TRAP   = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_ILLEGAL   = 2'd1,
        CAUSE_BAD_SEL   = 2'd2,
        CAUSE_STALL_TMO = 2'd3
    } trap_cause_e;

endpackage

// File: rtl/exu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// exu_seq_ctrl_if
// Fetch / decode / execution-unit handshake bundle around the sequencer.
//   master (sequencer): drives fetch_req, unit_en, cycle_cnt, pc_upd;
//                       receives fetch_ack, dec_valid, dec_unit_sel,
//                       dec_illegal, unit_stall.
//   slave  (fetch/decoder/units): the opposite directions.
// ---------------------------------------------------------------------------
interface exu_seq_ctrl_if
    import exu_pkg::*;
#(
    parameter int NUM_UNITS = NUM_UNITS_DEF
);

    logic                 fetch_req;
    logic                 fetch_ack;
    logic                 dec_valid;
    logic [NUM_UNITS-1:0] dec_unit_sel;
    logic                 dec_illegal;
    logic [NUM_UNITS-1:0] unit_stall;
    logic [NUM_UNITS-1:0] unit_en;
    logic [3:0]           cycle_cnt;
    logic                 pc_upd;

    modport master (
        output fetch_req, unit_en, cycle_cnt, pc_upd,
        input  fetch_ack, dec_valid, dec_unit_sel, dec_illegal, unit_stall
    );

    modport slave (
        input  fetch_req, unit_en, cycle_cnt, pc_upd,
        output fetch_ack, dec_valid, dec_unit_sel, dec_illegal, unit_stall
    );

endinterface

// File: rtl/exu_onehot_chk.sv
// ---------------------------------------------------------------------------
// exu_onehot_chk
// Combinational classifier for a unit-select vector.
//   vec       in  NUM_UNITS  vector under test
//   is_onehot out 1          exactly one bit set
//   is_zero   out 1          no bit set
// ---------------------------------------------------------------------------
module exu_onehot_chk
    import exu_pkg::*;
#(
    parameter int NUM_UNITS = NUM_UNITS_DEF
) (
    input  logic [NUM_UNITS-1:0] vec,
    output logic                 is_onehot,
    output logic                 is_zero
);

    localparam logic [NUM_UNITS-1:0] ONE = NUM_UNITS'(1);

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    always_comb begin
        is_zero   = (vec == '0);
        is_onehot = !is_zero && ((vec & (vec - ONE)) == '0);
    end

endmodule

// File: rtl/exu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// exu_seq_ctrl
// Instruction sequencer for the multi-cycle execution units. Requests fetch,
// waits for decode, enables exactly one unit while stepping the shared phase
// counter, and retires with a one-cycle PC-update pulse. Being the only source
// of unit enables keeps the shared regfile buses single-driven.
//   hclk, hrstn  clock, asynchronous active-low reset
//   run          level: start/continue sequencing
//   halt         level: stop after the current instruction retires
//   clr_trap     pulse: leave TRAP
//   bus          exu_seq_ctrl_if.master (fetch, decode, unit enables/stalls,
//                cycle_cnt, pc_upd)
//   trap         sticky trap flag
//   trap_cause   0 none, 1 illegal, 2 bad select, 3 stall timeout
//   instret      retired-instruction counter (wraps)
//   idle         FSM in IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module exu_seq_ctrl
    import exu_pkg::*;
#(
    parameter int NUM_UNITS   = NUM_UNITS_DEF,
    parameter int EXEC_CYCLES = EXEC_CYCLES_DEF,  // 3..15
    parameter int STALL_MAX   = STALL_MAX_DEF     // 1..255
) (
    input  logic                  hclk,
    input  logic                  hrstn,
    input  logic                  run,
    input  logic                  halt,
    input  logic                  clr_trap,
    exu_seq_ctrl_if.master        bus,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [31:0]           instret,
    output logic                  idle
);

    seq_state_e           state_q,  state_nxt;
    logic [NUM_UNITS-1:0] sel_q,    sel_nxt;
    logic [3:0]           cnt_q,    cnt_nxt;
    logic [7:0]           stall_q,  stall_nxt;
    trap_cause_e          cause_q,  cause_nxt;

    logic sel_onehot;
    logic sel_zero;
    logic sel_stall;

    exu_onehot_chk #(.NUM_UNITS(NUM_UNITS)) u_onehot_chk (
        .vec       (bus.dec_unit_sel),
        .is_onehot (sel_onehot),
        .is_zero   (sel_zero)
    );

    // Only the selected unit may hold the final phase.
    assign sel_stall     = |(bus.unit_stall & sel_q);
    assign bus.cycle_cnt = cnt_q;
    assign trap_cause    = cause_q;

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state_q;
        sel_nxt   = sel_q;
        cnt_nxt   = cnt_q;
        stall_nxt = stall_q;
        cause_nxt = cause_q;

        unique case (state_q)
            ST_IDLE: begin
                if (run && !halt) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.fetch_ack) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (bus.dec_valid) begin
                    if (bus.dec_illegal) begin
                        state_nxt = ST_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end else if (sel_zero || !sel_onehot) begin
                        state_nxt = ST_TRAP;
                        cause_nxt = CAUSE_BAD_SEL;
                    end else begin
                        state_nxt = ST_EXEC;
                        sel_nxt   = bus.dec_unit_sel;
                        cnt_nxt   = 4'd1;
                        stall_nxt = '0;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q != 4'(EXEC_CYCLES)) begin
                    cnt_nxt = cnt_q + 4'd1;
                end else if (!sel_stall) begin
                    state_nxt = ST_RETIRE;
                    sel_nxt   = '0;
                    cnt_nxt   = 4'd0;
                end else if (stall_q == 8'(STALL_MAX - 1)) begin
                    // This stall cycle is the STALL_MAX-th consecutive one.
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_STALL_TMO;
                    sel_nxt   = '0;
                    cnt_nxt   = 4'd0;
                end else begin
                    stall_nxt = stall_q + 8'd1;
                end
            end
            ST_RETIRE: begin
                state_nxt = (halt || !run) ? ST_IDLE : ST_FETCH;
            end
            ST_TRAP: begin
                if (clr_trap) begin
                    state_nxt = ST_IDLE;
                    cause_nxt = CAUSE_NONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe without a decode stage after the flops.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values
    // regardless of statement order.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            cnt_q         <= 4'd0;
            stall_q       <= '0;
            cause_q       <= CAUSE_NONE;
            bus.fetch_req <= 1'b0;
            bus.unit_en   <= '0;
            bus.pc_upd    <= 1'b0;
            trap          <= 1'b0;
            instret       <= '0;
            idle          <= 1'b1;
        end else begin
            state_q       <= state_nxt;
            sel_q         <= sel_nxt;
            cnt_q         <= cnt_nxt;
            stall_q       <= stall_nxt;
            cause_q       <= cause_nxt;
            bus.fetch_req <= (state_nxt == ST_FETCH);
            bus.unit_en   <= (state_nxt == ST_EXEC) ? sel_nxt : '0;
            bus.pc_upd    <= (state_nxt == ST_RETIRE);
            trap          <= (state_nxt == ST_TRAP);
            idle          <= (state_nxt == ST_IDLE);
            if (state_nxt == ST_RETIRE) instret <= instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exu_seq_ctrl
// Scoreboarded bench for exu_seq_ctrl: the driver issues instructions and
// pushes the outcome predicted from the sequencing rules; a monitor pops and
// compares on every retire pulse or trap entry.
// ---------------------------------------------------------------------------
module tb_exu_seq_ctrl;
    import exu_pkg::*;

    localparam int NU   = 8;
    localparam int EXC  = 4;
    localparam int SMAX = 4;

    localparam int M_NONE = 0;  // plain retire, refetch
    localparam int M_HALT = 1;  // halt raised mid-exec
    localparam int M_STOP = 2;  // run dropped mid-exec
    localparam int M_RST  = 3;  // async reset at phase 3

    logic        hclk = 1'b0;
    logic        hrstn;
    logic        run;
    logic        halt;
    logic        clr_trap;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    logic        idle;

    exu_seq_ctrl_if #(.NUM_UNITS(NU)) bus ();

    exu_seq_ctrl #(
        .NUM_UNITS   (NU),
        .EXEC_CYCLES (EXC),
        .STALL_MAX   (SMAX)
    ) dut (
        .hclk       (hclk),
        .hrstn      (hrstn),
        .run        (run),
        .halt       (halt),
        .clr_trap   (clr_trap),
        .bus        (bus),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret),
        .idle       (idle)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        bit            is_trap;
        logic [1:0]    cause;
        logic [31:0]   instret;
        logic [NU-1:0] sel;      // unit expected to be enabled, 0 if none
        int            len;      // first exec cycle .. event cycle inclusive
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_instret = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference outcome of one instruction from the decode/stall rules.
    function automatic exp_t model(input bit illegal, input logic [NU-1:0] sel, input int stall_len);
        exp_t r;
        r.is_trap = 1'b1;
        r.sel     = '0;
        r.len     = 0;
        r.instret = model_instret;
        if (illegal) begin
            r.cause = 2'd1;
        end else if ($countones(sel) != 1) begin
            r.cause = 2'd2;
        end else begin
            r.sel = sel;
            if (stall_len >= SMAX) begin
                r.cause = 2'd3;
                r.len   = EXC + SMAX;
            end else begin
                r.is_trap = 1'b0;
                r.cause   = 2'd0;
                r.len     = EXC + stall_len + 1;
                r.instret = model_instret + 32'd1;
            end
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    bit            in_exec;
    int            t_exec;
    logic [NU-1:0] seen_sel;
    bit            trap_prev;
    exp_t          mon_e;

    always @(negedge hclk) begin
        if (!hrstn) begin
            in_exec   = 1'b0;
            t_exec    = 0;
            trap_prev = 1'b0;
        end else begin
            check("en_onehot", 32'($countones(bus.unit_en) <= 1), 32'd1);
            check("en_at_cnt0", 32'(bus.unit_en != '0 && bus.cycle_cnt == 4'd0), 32'd0);
            if (bus.unit_en != '0) begin
                if (!in_exec) begin
                    in_exec  = 1'b1;
                    t_exec   = 0;
                    seen_sel = bus.unit_en;
                end
                t_exec++;
                check("cycle_cnt", 32'(bus.cycle_cnt), 32'((t_exec < EXC) ? t_exec : EXC));
                check("en_stable", 32'(bus.unit_en), 32'(seen_sel));
            end
            if (bus.pc_upd || (trap && !trap_prev)) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_event", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("event_is_trap", 32'(trap), 32'(mon_e.is_trap));
                    check("event_pc_upd", 32'(bus.pc_upd), 32'(!mon_e.is_trap));
                    check("trap_cause", 32'(trap_cause), 32'(mon_e.cause));
                    check("instret", instret, mon_e.instret);
                    check("exec_sel", 32'(in_exec ? seen_sel : '0), 32'(mon_e.sel));
                    if (mon_e.sel != '0) check("exec_len", 32'(t_exec + 1), 32'(mon_e.len));
                end
                in_exec = 1'b0;
                t_exec  = 0;
            end
            trap_prev = trap;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic wait_fetch(output bit ok);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.fetch_req && n < 50);
        ok = bus.fetch_req;
        if (!ok) check("fetch_req_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        hrstn          = 1'b0;
        bus.unit_stall = '0;
        bus.fetch_ack  = 1'b0;
        bus.dec_valid  = 1'b0;
        clr_trap       = 1'b0;
        halt           = 1'b0;
        run            = 1'b1;
        #1;
        check("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
        check("rst_unit_en", 32'(bus.unit_en), 32'd0);
        check("rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
        check("rst_pc_upd", 32'(bus.pc_upd), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_trap_cause", 32'(trap_cause), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        sb_q.delete();
        model_instret = '0;
        tick();
        tick();
        hrstn = 1'b1;
    endtask

    task automatic handle_trap();
        repeat ($urandom_range(1, 4)) begin
            check("trap_held", 32'(trap), 32'd1);
            check("trap_no_fetch", 32'(bus.fetch_req), 32'd0);
            run  = 1'($urandom);
            halt = 1'($urandom);
            tick();
        end
        check("trap_held", 32'(trap), 32'd1);
        run      = 1'b1;
        halt     = 1'b0;
        clr_trap = 1'b1;
        tick();
        clr_trap = 1'b0;
        check("clr_idle", 32'(idle), 32'd1);
        check("clr_trap_flag", 32'(trap), 32'd0);
        check("clr_cause", 32'(trap_cause), 32'd0);
    endtask

    task automatic do_instr(input bit illegal, input logic [NU-1:0] sel,
                            input int stall_len, input int mode);
        bit   ok;
        exp_t e;
        int   n_stall;
        bit   sbit;
        bit   done;
        wait_fetch(ok);
        if (!ok) return;
        repeat ($urandom_range(0, 3)) tick();
        bus.fetch_ack = 1'b1;
        tick();
        bus.fetch_ack = 1'b0;
        // Garbage on the decoder outputs must be ignored until dec_valid.
        repeat ($urandom_range(0, 3)) begin
            bus.dec_unit_sel = NU'($urandom);
            bus.dec_illegal  = 1'($urandom);
            tick();
        end
        bus.dec_valid    = 1'b1;
        bus.dec_unit_sel = sel;
        bus.dec_illegal  = illegal;
        e = model(illegal, sel, stall_len);
        sb_q.push_back(e);
        if (!e.is_trap) model_instret = e.instret;
        tick();
        bus.dec_valid    = 1'b0;
        bus.dec_unit_sel = NU'($urandom);
        bus.dec_illegal  = 1'($urandom);

        if (e.sel != '0) begin
            n_stall = 0;
            done    = 1'b0;
            for (int t = 1; !done; t++) begin
                if (t == 3 && mode == M_RST) begin
                    apply_reset();
                    return;
                end
                if (t < EXC) begin
                    sbit = 1'($urandom);
                end else if (n_stall < stall_len) begin
                    sbit = 1'b1;
                    n_stall++;
                end else begin
                    sbit = 1'b0;
                end
                bus.unit_stall = (NU'($urandom) & ~sel) | (sbit ? sel : '0);
                bus.fetch_ack  = 1'($urandom);
                clr_trap       = 1'($urandom);
                if (t == 2 && mode == M_HALT) halt = 1'b1;
                if (t == 2 && mode == M_STOP) run  = 1'b0;
                done = (t >= EXC && !sbit) || (n_stall >= SMAX);
                tick();
            end
            bus.unit_stall = '0;
            bus.fetch_ack  = 1'b0;
            clr_trap       = 1'b0;
        end

        if (e.is_trap) begin
            handle_trap();
        end else if (mode == M_NONE) begin
            tick();
            check("refetch_after_retire", 32'(bus.fetch_req), 32'd1);
        end else begin
            tick();
            check("idle_after_stop", 32'(idle), 32'd1);
            check("no_fetch_after_stop", 32'(bus.fetch_req), 32'd0);
            tick();
            check("no_fetch_hold", 32'(bus.fetch_req), 32'd0);
            halt = 1'b0;
            run  = 1'b1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            il;
        logic [NU-1:0] s;
        int            st;
        int            md;
        int            mode;

        bus.fetch_ack    = 1'b0;
        bus.dec_valid    = 1'b0;
        bus.dec_unit_sel = '0;
        bus.dec_illegal  = 1'b0;
        bus.unit_stall   = '0;
        hrstn    = 1'b0;
        run      = 1'b0;
        halt     = 1'b0;
        clr_trap = 1'b0;

        repeat (2) @(posedge hclk);
        #1;
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_fetch_req", 32'(bus.fetch_req), 32'd0);
        check("reset_unit_en", 32'(bus.unit_en), 32'd0);
        check("reset_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
        check("reset_instret", instret, 32'd0);
        check("reset_trap", 32'(trap), 32'd0);
        hrstn = 1'b1;
        tick();
        check("idle_without_run", 32'(idle), 32'd1);
        check("no_fetch_without_run", 32'(bus.fetch_req), 32'd0);
        run = 1'b1;

        // Directed cases.
        do_instr(1'b0, 8'(1 << EXU_IMM), 0, M_NONE);
        do_instr(1'b0, 8'(1 << EXU_BR), 3, M_NONE);      // stall just under limit
        do_instr(1'b1, 8'(1 << EXU_REG), 0, M_NONE);     // illegal
        do_instr(1'b0, 8'h06, 0, M_NONE);                // two bits
        do_instr(1'b0, 8'h00, 0, M_NONE);                // no bits
        do_instr(1'b1, 8'h06, 0, M_NONE);                // illegal wins over bad sel
        do_instr(1'b0, 8'(1 << EXU_LSU), SMAX, M_NONE);  // stall timeout
        do_instr(1'b0, 8'(1 << EXU_REG), 0, M_HALT);
        do_instr(1'b0, 8'(1 << EXU_MUL), 1, M_STOP);
        do_instr(1'b0, 8'(1 << EXU_DIV), 0, M_NONE);
        do_instr(1'b0, 8'(1 << EXU_CSR), 0, M_RST);
        do_instr(1'b0, 8'(1 << EXU_SYS), 0, M_NONE);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            il = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 3) != 0) ? (NU'(1) << $urandom_range(0, NU - 1)) : NU'($urandom);
            st = $urandom_range(0, SMAX + 1);
            md = $urandom_range(0, 9);
            mode = (md == 0) ? M_HALT : (md == 1) ? M_STOP : (md == 2) ? M_RST : M_NONE;
            if (mode == M_RST && (il || $countones(s) != 1)) mode = M_NONE;
            do_instr(il, s, st, mode);
        end

        repeat (5) tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
